// File: rtl/ram8_pkg.sv
// Shared definitions for the ram8 storage block and its access sequencer.
package ram8_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        RISSUE = 3'd2,
        RCAP   = 3'd3,
        RHOLD  = 3'd4,
        DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/ram8.sv
// 2**AW x DW synchronous storage block; read data appears the cycle after en&r.
module ram8
    import ram8_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          w,
    input  logic          r,
    input  logic [AW-1:0] add,
    input  logic [DW-1:0] d_in,
    output logic [DW-1:0] d_out
);

    logic [DW-1:0] mem_q [2**AW];

    // Storage array: written on en&w, contents are not reset.
    always_ff @(posedge clk) begin
        if (en && w) begin
            mem_q[add] <= d_in;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out <= '0;
        end else if (en && r) begin
            d_out <= mem_q[add];
        end else begin
            d_out <= d_out;
        end
    end

endmodule

// File: rtl/ram8_master.sv
// Burst access sequencer driving one ram8 instance from host commands.
// Optional abort port pair enabled by defining RAM8_MASTER_ABORT_EN.
module ram8_master
    import ram8_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          done,
`ifdef RAM8_MASTER_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          ram_en,
    output logic          ram_w,
    output logic          ram_r,
    output logic [AW-1:0] ram_add,
    output logic [DW-1:0] ram_d_in,
    input  logic [DW-1:0] ram_d_out
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          wr_ready_q, wr_ready_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;
`ifdef RAM8_MASTER_ABORT_EN
    logic          aborted_q, aborted_d;
`endif

    // Next-state, address/count update and RAM strobe generation.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        rd_data_d = rd_data_q;
        ram_en    = 1'b0;
        ram_w     = 1'b0;
        ram_r     = 1'b0;
        ram_add   = '0;
        ram_d_in  = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_base;
                    rem_d   = cmd_len;
                    state_d = (cmd_op == OP_WR) ? WRITE : RISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                ram_w    = 1'b1;
                ram_en   = wr_valid;
                ram_add  = addr_q;
                ram_d_in = wr_data;
                if (wr_valid && rem_q == '0) begin
                    state_d = DONE;
                end else if (wr_valid) begin
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - AW'(1);
                end else begin
                    state_d = WRITE;
                end
            end
            RISSUE: begin
                ram_en  = 1'b1;
                ram_r   = 1'b1;
                ram_add = addr_q;
                state_d = RCAP;
            end
            RCAP: begin
                rd_data_d = ram_d_out;
                state_d   = RHOLD;
            end
            RHOLD: begin
                if (rd_ready && rem_q == '0) begin
                    state_d = DONE;
                end else if (rd_ready) begin
                    // Issue the next strobe during the handshake: 2 cycles per word.
                    addr_d  = addr_q + AW'(1);
                    rem_d   = rem_q - AW'(1);
                    ram_en  = 1'b1;
                    ram_r   = 1'b1;
                    ram_add = addr_q + AW'(1);
                    state_d = RCAP;
                end else begin
                    state_d = RHOLD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef RAM8_MASTER_ABORT_EN
        // DONE is excluded so an abort cannot produce a second done pulse.
        if (abort && state_q != IDLE && state_q != DONE) begin
            state_d   = DONE;
            addr_d    = addr_q;
            rem_d     = rem_q;
            rd_data_d = rd_data_q;
            ram_en    = 1'b0;
            ram_w     = 1'b0;
            ram_r     = 1'b0;
            ram_add   = '0;
            ram_d_in  = '0;
            aborted_d = 1'b1;
        end else begin
            aborted_d = 1'b0;
        end
`endif

        cmd_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WRITE);
        rd_valid_d  = (state_d == RHOLD);
        done_d      = (state_d == DONE);
    end

    // Sequencer state and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            rd_data_q   <= '0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef RAM8_MASTER_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            rd_data_q   <= rd_data_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
`ifdef RAM8_MASTER_ABORT_EN
            aborted_q   <= aborted_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
`ifdef RAM8_MASTER_ABORT_EN
    assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_ram8_master.sv
// Randomized bench for ram8_master paired with a real ram8; a shadow memory array
// predicts every read word, and cycle-level protocol timing is checked per burst.
module tb_ram8_master;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [AW-1:0] cmd_base, cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          ram_en, ram_w, ram_r;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_d_in, ram_d_out;
`ifdef RAM8_MASTER_ABORT_EN
    logic          abort, aborted;
`endif

    int total = 0;
    int bad = 0;
    int rd_strobes = 0;
    int overlap = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] wdat [DEPTH];

    ram8_master #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done),
`ifdef RAM8_MASTER_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .ram_en(ram_en), .ram_w(ram_w), .ram_r(ram_r),
        .ram_add(ram_add), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
    );

    ram8 #(.DW(DW), .AW(AW)) u_ram (
        .clk(clk), .rst_n(rst_n), .en(ram_en), .w(ram_w), .r(ram_r),
        .add(ram_add), .d_in(ram_d_in), .d_out(ram_d_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en && ram_r) rd_strobes <= rd_strobes + 1;
        if (ram_w && ram_r) overlap <= overlap + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rest(input bit with_rd);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ram_en", 32'(ram_en), 32'd0);
        check_eq("rst_ram_w", 32'(ram_w), 32'd0);
        check_eq("rst_ram_r", 32'(ram_r), 32'd0);
        check_eq("rst_ram_add", 32'(ram_add), 32'd0);
        check_eq("rst_ram_d_in", 32'(ram_d_in), 32'd0);
        if (with_rd) check_eq("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef RAM8_MASTER_ABORT_EN
        check_eq("rst_aborted", 32'(aborted), 32'd0);
`endif
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        check_eq("idle_wait", 32'(cmd_ready), 32'd1);
    endtask

    // mode 0: wr_valid always high, 1: toggling 1-0-1-0, 2: random gaps
    task automatic do_write(input logic [AW-1:0] base, input logic [AW-1:0] len, input int mode);
        int k = 0;
        int n = 0;
        logic v;
        logic [AW-1:0] a;
        wait_idle();
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = base; cmd_len = len;
        cyc();
        cmd_valid = 1'b0;
        while (k <= int'(len) && n < 200) begin
            case (mode)
                0: v = 1'b1;
                1: v = (n % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            a = base + k[AW-1:0];
            wr_valid = v; wr_data = wdat[k];
            #1;
            check_eq("wr_ready", 32'(wr_ready), 32'd1);
            check_eq("wr_done_early", 32'(done), 32'd0);
            check_eq("wr_ram_en", 32'(ram_en), 32'(v));
            check_eq("wr_ram_w", 32'(ram_w), 32'd1);
            check_eq("wr_ram_r", 32'(ram_r), 32'd0);
            if (v) begin
                check_eq("wr_ram_add", 32'(ram_add), 32'(a));
                check_eq("wr_ram_d_in", 32'(ram_d_in), 32'(wdat[k]));
            end
            cyc();
            if (v) begin
                model[a] = wdat[k];
                k++;
            end
            n++;
        end
        wr_valid = 1'b0;
        if (mode == 0) check_eq("wr_cycles", 32'(n), 32'(int'(len) + 1));
        #1;
        check_eq("wr_done", 32'(done), 32'd1);
        check_eq("wr_done_ram_en", 32'(ram_en), 32'd0);
        check_eq("wr_done_cmd_ready", 32'(cmd_ready), 32'd0);
        cyc();
        check_eq("wr_done_once", 32'(done), 32'd0);
        check_eq("wr_back_idle", 32'(cmd_ready), 32'd1);
    endtask

    // mode 0: no stalls, 1: 5-cycle stall on word index 1, 2: random stalls
    task automatic do_read(input logic [AW-1:0] base, input logic [AW-1:0] len, input int mode);
        int s0;
        int st;
        logic [AW-1:0] a;
        wait_idle();
        s0 = rd_strobes;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = base; cmd_len = len;
        rd_ready = 1'b0;
        wr_valid = 1'b1; wr_data = DW'($urandom);
        cyc();
        cmd_valid = 1'b0;
        #1;
        check_eq("rd_issue_en", 32'(ram_en), 32'd1);
        check_eq("rd_issue_r", 32'(ram_r), 32'd1);
        check_eq("rd_issue_w", 32'(ram_w), 32'd0);
        check_eq("rd_issue_add", 32'(ram_add), 32'(base));
        check_eq("rd_issue_valid", 32'(rd_valid), 32'd0);
        cyc();
        check_eq("rd_cap_en", 32'(ram_en), 32'd0);
        check_eq("rd_cap_valid", 32'(rd_valid), 32'd0);
        for (int k = 0; k <= int'(len); k++) begin
            a = base + k[AW-1:0];
            case (mode)
                0: st = 0;
                1: st = (k == 1) ? 5 : 0;
                default: st = int'($urandom_range(0, 3));
            endcase
            cyc();
            for (int j = 0; j < st; j++) begin
                rd_ready = 1'b0;
                #1;
                check_eq("rd_stall_valid", 32'(rd_valid), 32'd1);
                check_eq("rd_stall_data", 32'(rd_data), 32'(model[a]));
                check_eq("rd_stall_en", 32'(ram_en), 32'd0);
                cyc();
            end
            rd_ready = 1'b1;
            #1;
            check_eq("rd_valid", 32'(rd_valid), 32'd1);
            check_eq("rd_data", 32'(rd_data), 32'(model[a]));
            check_eq("rd_done_early", 32'(done), 32'd0);
            check_eq("rd_no_w", 32'(ram_w), 32'd0);
            if (k < int'(len)) begin
                check_eq("rd_next_en", 32'(ram_en), 32'd1);
                check_eq("rd_next_r", 32'(ram_r), 32'd1);
                check_eq("rd_next_add", 32'(ram_add), 32'(AW'(a + AW'(1))));
            end else begin
                check_eq("rd_last_en", 32'(ram_en), 32'd0);
            end
            cyc();
            rd_ready = 1'b0;
            if (k < int'(len)) begin
                check_eq("rd_gap_valid", 32'(rd_valid), 32'd0);
                check_eq("rd_gap_en", 32'(ram_en), 32'd0);
            end
        end
        wr_valid = 1'b0;
        #1;
        check_eq("rd_done", 32'(done), 32'd1);
        check_eq("rd_done_valid", 32'(rd_valid), 32'd0);
        check_eq("rd_done_en", 32'(ram_en), 32'd0);
        cyc();
        check_eq("rd_done_once", 32'(done), 32'd0);
        check_eq("rd_back_idle", 32'(cmd_ready), 32'd1);
        check_eq("rd_strobes", 32'(rd_strobes - s0), 32'(int'(len) + 1));
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
`ifdef RAM8_MASTER_ABORT_EN
        abort = 1'b0;
`endif
        cyc();
        cyc();
        check_rest(1'b1);
        rst_n = 1'b1;
        cyc();
        check_rest(1'b1);

        // Full write then in-order read-back.
        for (int i = 0; i < DEPTH; i++) wdat[i] = DW'(i + 1);
        do_write(3'd0, 3'd7, 0);
        do_read(3'd0, 3'd7, 0);

        // Wrap-around burst 6,7,0,1.
        for (int i = 0; i < 4; i++) wdat[i] = DW'(16'hA + i);
        do_write(3'd6, 3'd3, 0);
        do_read(3'd6, 3'd3, 0);
        do_read(3'd0, 3'd7, 0);

        // Read backpressure, then write stalls.
        do_read(3'd0, 3'd7, 1);
        for (int i = 0; i < 4; i++) wdat[i] = DW'(16'h100 + i);
        do_write(3'd2, 3'd3, 1);
        do_read(3'd0, 3'd7, 0);

        // Random bursts.
        for (int it = 0; it < 10; it++) begin
            logic [AW-1:0] b, l;
            b = AW'($urandom_range(0, 7));
            l = AW'($urandom_range(0, 7));
            for (int i = 0; i < DEPTH; i++) wdat[i] = DW'($urandom);
            do_write(b, l, 2);
            do_read(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 2);
        end

        // Reset in the middle of a read burst.
        wait_idle();
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 3'd0; cmd_len = 3'd7;
        rd_ready = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        check_rest(1'b1);
        cyc();
        rst_n = 1'b1;
        cyc();
        check_rest(1'b1);
        do_read(3'd0, 3'd7, 2);

`ifdef RAM8_MASTER_ABORT_EN
        // Abort on the third word of a write burst.
        wait_idle();
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 3'd0; cmd_len = 3'd7;
        cyc();
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_valid = 1'b1; wr_data = DW'(16'h500 + k);
            cyc();
            model[k] = DW'(16'h500 + k);
        end
        wr_valid = 1'b1; wr_data = 16'h5FF;
        abort = 1'b1;
        #1;
        check_eq("abort_no_en", 32'(ram_en), 32'd0);
        check_eq("abort_no_w", 32'(ram_w), 32'd0);
        cyc();
        abort = 1'b0; wr_valid = 1'b0;
        #1;
        check_eq("abort_done", 32'(done), 32'd1);
        check_eq("abort_flag", 32'(aborted), 32'd1);
        cyc();
        check_rest(1'b0);
        do_read(3'd0, 3'd7, 0);
        abort = 1'b1;
        cyc();
        check_eq("abort_idle_ignored", 32'(aborted), 32'd0);
        abort = 1'b0;
        check_rest(1'b0);
`endif

        check_eq("w_r_overlap", 32'(overlap), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
